fifo_ctrl_sync: RTL and testbench

Single-clock FIFO controller that drives the dedicated write port and dedicated read port of the team's dual-port SRAM wrapper. It owns the binary write/read pointers, accepts requests from the producer and consumer, gates the SRAM enables, and reports fill level, full/empty, almost-full/almost-empty and sticky error flags. It sits between the FIFO top level and the SRAM instance, with both SRAM clock ports tied to the same `clk`.

---
 rtl/fifo_ctrl_sync_pkg.sv | 23 ++
 rtl/fifo_ctrl_sync_ptr_ctrl.sv | 36 +++
 rtl/fifo_ctrl_sync.sv | 123 ++++++++++++
 tb/tb_fifo_ctrl_sync.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_ctrl_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ctrl_sync_pkg
// Description : Shared sizing constants and operation encoding for the
//               single-clock FIFO controller.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_ctrl_sync_pkg;

  // Default data and address widths of the dual-port SRAM wrapper
  localparam int c_d_length = 8;
  localparam int c_a_length = 4;

  // Accepted operations for one clock edge, packed as {write, read}
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage : fifo_ctrl_sync_pkg
`default_nettype wire

// File: rtl/fifo_ctrl_sync_ptr_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ptr_ctrl
// Description : One FIFO pointer with wrap bit plus its request-accept gate.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ptr_ctrl #(
  parameter int A_LENGTH = fifo_ctrl_sync_pkg::c_a_length
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req,
  input  logic                blocked,
  output logic                acc,
  output logic [A_LENGTH-1:0] addr,
  output logic [A_LENGTH:0]   ptr_next
);

  localparam logic [A_LENGTH:0] c_one = {{A_LENGTH{1'b0}}, 1'b1};

  logic [A_LENGTH:0] r_ptr;

  assign acc      = req & ~blocked;
  assign ptr_next = acc ? (r_ptr + c_one) : r_ptr;
  assign addr     = r_ptr[A_LENGTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else begin
      r_ptr <= ptr_next;
    end
  end

endmodule : fifo_ptr_ctrl
`default_nettype wire

// File: rtl/fifo_ctrl_sync.sv
`default_nettype none
// ============================================================================
// Module      : fifo_ctrl_sync
// Description : Single-clock FIFO controller driving a dual-port SRAM wrapper.
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_ctrl_sync
  import fifo_ctrl_sync_pkg::*;
#(
  parameter int D_LENGTH = c_d_length,
  parameter int A_LENGTH = c_a_length,
  parameter int AF_LEVEL = (2 ** A_LENGTH) - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_req,
  input  logic [D_LENGTH-1:0] wr_data_in,
  input  logic                rd_req,
  output logic                mem_wr_en,
  output logic [A_LENGTH-1:0] mem_wr_addr,
  output logic [D_LENGTH-1:0] mem_wr_data,
  output logic                mem_rd_en,
  output logic [A_LENGTH-1:0] mem_rd_addr,
  output logic                rd_valid,
  output logic [A_LENGTH:0]   count,
  output logic                full,
  output logic                empty,
  output logic                almost_full,
  output logic                almost_empty,
  output logic                wr_overflow,
  output logic                rd_underflow
);

  localparam logic [A_LENGTH:0] c_one      = {{A_LENGTH{1'b0}}, 1'b1};
  localparam logic [A_LENGTH:0] c_af_level = (A_LENGTH + 1)'(AF_LEVEL);
  localparam logic [A_LENGTH:0] c_ae_level = (A_LENGTH + 1)'(AE_LEVEL);

  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [A_LENGTH:0] w_wr_ptr_next;
  logic [A_LENGTH:0] w_rd_ptr_next;
  logic [A_LENGTH:0] w_count_next;
  fifo_op_e          w_op;

  logic              r_full;
  logic              r_empty;
  logic [A_LENGTH:0] r_count;
  logic              r_almost_full;
  logic              r_almost_empty;
  logic              r_rd_valid;
  logic              r_wr_overflow;
  logic              r_rd_underflow;

  fifo_ptr_ctrl #(.A_LENGTH(A_LENGTH)) u_wr_ptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (wr_req),
    .blocked  (r_full),
    .acc      (w_wr_acc),
    .addr     (mem_wr_addr),
    .ptr_next (w_wr_ptr_next)
  );

  fifo_ptr_ctrl #(.A_LENGTH(A_LENGTH)) u_rd_ptr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (rd_req),
    .blocked  (r_empty),
    .acc      (w_rd_acc),
    .addr     (mem_rd_addr),
    .ptr_next (w_rd_ptr_next)
  );

  assign w_op = fifo_op_e'({w_wr_acc, w_rd_acc});

  always_comb begin
    w_count_next = r_count;
    case (w_op)
      OP_PUSH: w_count_next = r_count + c_one;
      OP_POP:  w_count_next = r_count - c_one;
      default: w_count_next = r_count;
    endcase
  end

  // Flags are registered from next-state values so they never see the requests combinationally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full         <= 1'b0;
      r_empty        <= 1'b1;
      r_count        <= '0;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
      r_rd_valid     <= 1'b0;
      r_wr_overflow  <= 1'b0;
      r_rd_underflow <= 1'b0;
    end else begin
      r_full         <= (w_wr_ptr_next[A_LENGTH] != w_rd_ptr_next[A_LENGTH]) &&
                        (w_wr_ptr_next[A_LENGTH-1:0] == w_rd_ptr_next[A_LENGTH-1:0]);
      r_empty        <= (w_wr_ptr_next == w_rd_ptr_next);
      r_count        <= w_count_next;
      r_almost_full  <= (w_count_next >= c_af_level);
      r_almost_empty <= (w_count_next <= c_ae_level);
      r_rd_valid     <= w_rd_acc;
      r_wr_overflow  <= r_wr_overflow | (wr_req & r_full);
      r_rd_underflow <= r_rd_underflow | (rd_req & r_empty);
    end
  end

  assign mem_wr_en    = w_wr_acc;
  assign mem_wr_data  = wr_data_in;
  assign mem_rd_en    = w_rd_acc;
  assign rd_valid     = r_rd_valid;
  assign count        = r_count;
  assign full         = r_full;
  assign empty        = r_empty;
  assign almost_full  = r_almost_full;
  assign almost_empty = r_almost_empty;
  assign wr_overflow  = r_wr_overflow;
  assign rd_underflow = r_rd_underflow;

endmodule : fifo_ctrl_sync
`default_nettype wire

// File: tb/tb_fifo_ctrl_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_fifo_ctrl_sync
// Description : Self-checking bench for fifo_ctrl_sync with a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_ctrl_sync;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wr_req = 1'b0;
  logic [DW-1:0] wr_data_in = '0;
  logic          rd_req = 1'b0;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic          mem_rd_en;
  logic [AW-1:0] mem_rd_addr;
  logic          rd_valid;
  logic [AW:0]   count;
  logic          full, empty, almost_full, almost_empty;
  logic          wr_overflow, rd_underflow;

  fifo_ctrl_sync dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_req       (wr_req),
    .wr_data_in   (wr_data_in),
    .rd_req       (rd_req),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_addr  (mem_wr_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_rd_en    (mem_rd_en),
    .mem_rd_addr  (mem_rd_addr),
    .rd_valid     (rd_valid),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .wr_overflow  (wr_overflow),
    .rd_underflow (rd_underflow)
  );

  always #5 clk = ~clk;

  // SRAM stand-in with registered read port
  logic [DW-1:0] sram [DEPTH];
  logic [DW-1:0] sram_q;
  always @(posedge clk) begin
    if (mem_wr_en) sram[mem_wr_addr] <= mem_wr_data;
    if (mem_rd_en) sram_q <= sram[mem_rd_addr];
  end

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: queue of stored words plus running totals of accepted operations
  logic [DW-1:0] q[$];
  int            m_wr_tot = 0;
  int            m_rd_tot = 0;
  bit            m_ovf = 1'b0;
  bit            m_unf = 1'b0;
  bit            m_rv  = 1'b0;
  logic [DW-1:0] m_rd_data = '0;
  bit            m_wa, m_ra;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        m_wr_tot = 0; m_rd_tot = 0;
        m_ovf = 1'b0; m_unf = 1'b0; m_rv = 1'b0;
      end else begin
        m_wa = wr_req && (q.size() < DEPTH);
        m_ra = rd_req && (q.size() > 0);
        if (wr_req && q.size() == DEPTH) m_ovf = 1'b1;
        if (rd_req && q.size() == 0) m_unf = 1'b1;
        m_rv = m_ra;
        if (m_ra) begin
          m_rd_data = q.pop_front();
          m_rd_tot++;
        end
        if (m_wa) begin
          q.push_back(wr_data_in);
          m_wr_tot++;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("count",        32'(count),        32'(q.size()));
        check("full",         32'(full),         32'(q.size() == DEPTH));
        check("empty",        32'(empty),        32'(q.size() == 0));
        check("almost_full",  32'(almost_full),  32'(q.size() >= DEPTH - 2));
        check("almost_empty", 32'(almost_empty), 32'(q.size() <= 2));
        check("wr_overflow",  32'(wr_overflow),  32'(m_ovf));
        check("rd_underflow", 32'(rd_underflow), 32'(m_unf));
        check("rd_valid",     32'(rd_valid),     32'(m_rv));
        check("mem_wr_en",    32'(mem_wr_en),    32'(wr_req && q.size() < DEPTH));
        check("mem_rd_en",    32'(mem_rd_en),    32'(rd_req && q.size() > 0));
        check("mem_wr_addr",  32'(mem_wr_addr),  32'(m_wr_tot % DEPTH));
        check("mem_rd_addr",  32'(mem_rd_addr),  32'(m_rd_tot % DEPTH));
        check("mem_wr_data",  32'(mem_wr_data),  32'(wr_data_in));
        if (m_rv) check("rd_data", 32'(sram_q), 32'(m_rd_data));
      end
    end
  end

  // Present inputs, then return just after the edge that samples them
  task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
    wr_req = w; wr_data_in = d; rd_req = r;
    @(posedge clk); #2;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_full",  32'(full),  32'd0);
    check("rst_ae",    32'(almost_empty), 32'd1);
    check("rst_af",    32'(almost_full),  32'd0);

    // Asynchronous reset in the middle of a write burst
    for (int k = 0; k < 3; k++) step(1'b1, 8'hA0 + 8'(k), 1'b0);
    check("burst_count", 32'(count), 32'd3);
    rst_n = 1'b0;
    #1;
    check("async_count", 32'(count), 32'd0);
    check("async_empty", 32'(empty), 32'd1);
    check("async_waddr", 32'(mem_wr_addr), 32'd0);
    check("async_ovf",   32'(wr_overflow), 32'd0);
    wr_req = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Fill to full
    for (int k = 0; k < 16; k++) begin
      step(1'b1, 8'(k), 1'b0);
      check("fill_count", 32'(count), 32'(k + 1));
      check("fill_af",    32'(almost_full),  32'(k + 1 >= 14));
      check("fill_ae",    32'(almost_empty), 32'(k + 1 <= 2));
    end
    check("fill_full", 32'(full), 32'd1);

    // Write while full
    wr_req = 1'b1; wr_data_in = 8'hEE; rd_req = 1'b0;
    #1 check("ovf_wr_en", 32'(mem_wr_en), 32'd0);
    @(posedge clk); #2;
    check("ovf_flag",  32'(wr_overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd16);
    check("ovf_waddr", 32'(mem_wr_addr), 32'd0);

    // Drain in order
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 8'h00, 1'b1);
      check("drain_valid", 32'(rd_valid), 32'd1);
      check("drain_data",  32'(sram_q), 32'(i));
    end
    check("drain_empty", 32'(empty), 32'd1);

    // Read while empty
    rd_req = 1'b1;
    #1 check("unf_rd_en", 32'(mem_rd_en), 32'd0);
    @(posedge clk); #2;
    check("unf_flag",  32'(rd_underflow), 32'd1);
    check("unf_valid", 32'(rd_valid), 32'd0);

    // Simultaneous requests while empty: write only
    step(1'b1, 8'h55, 1'b1);
    check("se_count", 32'(count), 32'd1);
    check("se_valid", 32'(rd_valid), 32'd0);
    step(1'b0, 8'h00, 1'b0);
    check("se_valid2", 32'(rd_valid), 32'd0);

    // Refill, then simultaneous requests while full: read only
    for (int k = 0; k < 15; k++) step(1'b1, 8'h60 + 8'(k), 1'b0);
    check("refill_full", 32'(full), 32'd1);
    step(1'b1, 8'hEE, 1'b1);
    check("sf_count", 32'(count), 32'd15);
    check("sf_full",  32'(full), 32'd0);
    check("sf_data",  32'(sram_q), 32'h55);

    // Fresh start, then sustained concurrent traffic across the wrap
    rst_n = 1'b0;
    #1;
    check("rst2_ovf", 32'(wr_overflow), 32'd0);
    check("rst2_unf", 32'(rd_underflow), 32'd0);
    step(1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) step(1'b1, 8'h80 + 8'(k), 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'hC0 + 8'(i), 1'b1);
      check("stream_count", 32'(count), 32'd5);
      if (i == 0) check("stream_first", 32'(sram_q), 32'h80);
    end
    check("stream_waddr", 32'(mem_wr_addr), 32'd13);
    check("stream_raddr", 32'(mem_rd_addr), 32'd8);
    for (int k = 0; k < 5; k++) step(1'b0, 8'h00, 1'b1);
    step(1'b0, 8'h00, 1'b0);
    check("end_empty", 32'(empty), 32'd1);
    step(1'b0, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_fifo_ctrl_sync
`default_nettype wire
